axis_bus_rr_mux: RTL and testbench



---
 rtl/axis_bus_rr_mux_pkg.sv | 19 +
 rtl/axis_bus_rr_mux_arbiter.sv | 52 +++++
 rtl/axis_bus_rr_mux.sv | 116 +++++++++++
 tb/tb_axis_bus_rr_mux.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_bus_rr_mux_pkg.sv
// Shared definitions for the AXI-Stream bus mux and its tready demux counterpart.
// Both sides agree on the bus_sel encoding defined here.
package axis_bus_rr_mux_pkg;

    localparam int NUM_CH_DEFAULT = 14;
    localparam int CH_IDX_W       = 7;

    localparam logic [7:0] BUS_SEL_BASE = 8'd128;
    localparam logic [7:0] BUS_SEL_NONE = 8'd0;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_XFER = 1'b1;

    function automatic logic [7:0] bus_sel_code(input logic [CH_IDX_W-1:0] ch);
        return BUS_SEL_BASE + {1'b0, ch};
    endfunction

endpackage

// File: rtl/axis_bus_rr_mux_arbiter.sv
// Combinational round-robin search: first requesting channel after last_grant,
// wrapping modulo NUM_CH.
module axis_rr_arbiter
    import axis_bus_rr_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_IDX_W-1:0] last_grant,
    input  logic                arb_en,
    output logic [CH_IDX_W-1:0] grant,
    output logic                grant_valid
);

    logic [CH_IDX_W-1:0] cand [NUM_CH];
    logic [NUM_CH-1:0]   hit;

    // cand[gi] is the channel at priority position gi (0 = highest).
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            logic [CH_IDX_W:0] sum;
            logic              hit_g;

            assign sum = {1'b0, last_grant} + (CH_IDX_W+1)'(gi + 1);
            assign cand[gi] = (sum >= (CH_IDX_W+1)'(NUM_CH))
                            ? CH_IDX_W'(sum - (CH_IDX_W+1)'(NUM_CH))
                            : sum[CH_IDX_W-1:0];

            always_comb begin
                hit_g = 1'b0;
                for (int j = 0; j < NUM_CH; j++) begin
                    if (cand[gi] == CH_IDX_W'(j)) begin
                        hit_g = req[j];
                    end
                end
            end

            assign hit[gi] = hit_g;
        end
    endgenerate

    always_comb begin
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                grant = cand[i];
            end
        end
        grant_valid = arb_en && (|hit);
    end

endmodule

// File: rtl/axis_bus_rr_mux.sv
// Packet-atomic round-robin mux of NUM_CH AXI-Stream channels onto one bus,
// with a single registered output stage and a published grant code (bus_sel).
module axis_bus_rr_mux
    import axis_bus_rr_mux_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEFAULT,
    parameter int DW     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    axis_in_tvalid,
    input  logic [NUM_CH*DW-1:0] axis_in_tdata,
    input  logic [NUM_CH-1:0]    axis_in_tlast,
    output logic [NUM_CH-1:0]    axis_in_tready,
    output logic                 axis_out_tvalid,
    output logic [DW-1:0]        axis_out_tdata,
    output logic                 axis_out_tlast,
    input  logic                 axis_out_tready,
    output logic [7:0]           bus_sel
);

    state_t              state_reg;
    logic [CH_IDX_W-1:0] grant_reg;
    logic [CH_IDX_W-1:0] last_grant_reg;
    logic [7:0]          bus_sel_reg;
    logic                out_valid_reg;
    logic [DW-1:0]       out_data_reg;
    logic                out_last_reg;

    logic [CH_IDX_W-1:0] arb_grant;
    logic                arb_valid;
    logic                in_ready;
    logic                xfer_ready;
    logic                accept;
    logic                sel_valid;
    logic                sel_last;
    logic [DW-1:0]       sel_data;

    axis_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .req         (axis_in_tvalid),
        .last_grant  (last_grant_reg),
        .arb_en      (state_reg == ST_IDLE),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_reg == CH_IDX_W'(i)) begin
                sel_valid = axis_in_tvalid[i];
                sel_last  = axis_in_tlast[i];
                sel_data  = axis_in_tdata[i*DW +: DW];
            end
        end
    end

    // The output register can take a beat when empty or when draining this cycle.
    assign in_ready   = !out_valid_reg || axis_out_tready;
    assign xfer_ready = (state_reg == ST_XFER) && in_ready;
    assign accept     = xfer_ready && sel_valid;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_tready
            assign axis_in_tready[gi] = xfer_ready && (grant_reg == CH_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= CH_IDX_W'(NUM_CH - 1);
            bus_sel_reg    <= BUS_SEL_NONE;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= sel_data;
                out_last_reg  <= sel_last;
            end else if (axis_out_tready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (arb_valid) begin
                        grant_reg   <= arb_grant;
                        bus_sel_reg <= bus_sel_code(arb_grant);
                        state_reg   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (accept && sel_last) begin
                        last_grant_reg <= grant_reg;
                        bus_sel_reg    <= BUS_SEL_NONE;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign axis_out_tvalid = out_valid_reg;
    assign axis_out_tdata  = out_data_reg;
    assign axis_out_tlast  = out_last_reg;
    assign bus_sel         = bus_sel_reg;

endmodule

// File: tb/tb_axis_bus_rr_mux.sv
// Scoreboard bench for axis_bus_rr_mux: directed arbitration/stall/reset scenarios
// followed by a randomized multi-channel traffic phase.
module tb_axis_bus_rr_mux;

    localparam int NC = 14;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    axis_in_tvalid;
    logic [NC*DW-1:0] axis_in_tdata;
    logic [NC-1:0]    axis_in_tlast;
    logic [NC-1:0]    axis_in_tready;
    logic             axis_out_tvalid;
    logic [DW-1:0]    axis_out_tdata;
    logic             axis_out_tlast;
    logic             axis_out_tready;
    logic [7:0]       bus_sel;

    beat_t         src_q [NC][$];
    beat_t         exp_q [$];
    beat_t         exp_ch_q [NC][$];
    int            vectors = 0;
    int            miscompares = 0;
    bit            rand_mode = 1'b0;
    logic [NC-1:0] acc_snap = '0;
    int            open_ch = -1;
    int            mon_ch;
    beat_t         mon_got;
    beat_t         mon_exp;

    always #5 clk = ~clk;

    axis_bus_rr_mux #(
        .NUM_CH (NC),
        .DW     (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tlast   (axis_in_tlast),
        .axis_in_tready  (axis_in_tready),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tlast  (axis_out_tlast),
        .axis_out_tready (axis_out_tready),
        .bus_sel         (bus_sel)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end else begin
            $display("ok   %s: 0x%0h", name, got);
        end
    endtask

    task automatic send_pkt(input int ch, input int len, input logic [31:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + 32'(k);
            b.last = (k == len - 1);
            src_q[ch].push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic flush_all();
        for (int c = 0; c < NC; c++) begin
            src_q[c].delete();
            exp_ch_q[c].delete();
        end
        exp_q.delete();
        acc_snap = '0;
        open_ch  = -1;
    endtask

    function automatic bit idle_all();
        bit r;
        r = (exp_q.size() == 0) && (bus_sel == 8'd0) && !axis_out_tvalid && (axis_in_tvalid == '0);
        for (int c = 0; c < NC; c++) begin
            if (src_q[c].size() != 0 || exp_ch_q[c].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_sel(input logic [7:0] v, input string name);
        int n;
        n = 0;
        while (bus_sel !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, bus_sel, v);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (!idle_all() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL %s: not idle after %0d cycles, exp_q=%0d expected idle", name, n, exp_q.size());
        end else begin
            $display("ok   %s: idle after %0d cycles", name, n);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        flush_all();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    // Input drivers: pop the beat accepted at the previous edge, present the next one.
    initial begin
        axis_in_tvalid = '0;
        axis_in_tdata  = '0;
        axis_in_tlast  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NC; c++) begin
                if (acc_snap[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
                if (src_q[c].size() > 0 && (!rand_mode || $urandom_range(3) != 0)) begin
                    axis_in_tvalid[c]          = 1'b1;
                    axis_in_tdata[c*DW +: DW]  = src_q[c][0].data;
                    axis_in_tlast[c]           = src_q[c][0].last;
                end else begin
                    axis_in_tvalid[c]          = 1'b0;
                    axis_in_tdata[c*DW +: DW]  = '0;
                    axis_in_tlast[c]           = 1'b0;
                end
            end
            if (rand_mode) axis_out_tready = ($urandom_range(2) != 0);
        end
    end

    // Monitor: scoreboard pops on every output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            acc_snap = axis_in_tvalid & axis_in_tready;
            vectors++;
            if ($countones(axis_in_tready) > 1) begin
                miscompares++;
                $display("FAIL onehot0: axis_in_tready=0x%0h required at most one bit", axis_in_tready);
            end
            if (axis_out_tvalid && axis_out_tready) begin
                vectors++;
                mon_got.data = axis_out_tdata;
                mon_got.last = axis_out_tlast;
                if (rand_mode) begin
                    mon_ch = int'(axis_out_tdata[31:24]);
                    if (mon_ch >= NC || exp_ch_q[mon_ch].size() == 0) begin
                        miscompares++;
                        $display("FAIL beat: unexpected 0x%0h last=%0b, required none", mon_got.data, mon_got.last);
                    end else if (open_ch != -1 && open_ch != mon_ch) begin
                        miscompares++;
                        $display("FAIL interleave: beat from ch%0d, required ch%0d", mon_ch, open_ch);
                    end else begin
                        mon_exp = exp_ch_q[mon_ch].pop_front();
                        if (mon_got !== mon_exp) begin
                            miscompares++;
                            $display("FAIL beat ch%0d: got 0x%0h/%0b expected 0x%0h/%0b",
                                     mon_ch, mon_got.data, mon_got.last, mon_exp.data, mon_exp.last);
                        end
                    end
                    open_ch = axis_out_tlast ? -1 : mon_ch;
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat: unexpected 0x%0h last=%0b, required none", mon_got.data, mon_got.last);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_got !== mon_exp) begin
                        miscompares++;
                        $display("FAIL beat: got 0x%0h/%0b expected 0x%0h/%0b",
                                 mon_got.data, mon_got.last, mon_exp.data, mon_exp.last);
                    end else begin
                        $display("ok   beat: 0x%0h last=%0b", mon_got.data, mon_got.last);
                    end
                end
            end
        end else begin
            acc_snap = '0;
        end
    end

    initial begin
        beat_t b;
        int    len;
        rst = 1'b0;
        axis_out_tready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_out_tvalid", axis_out_tvalid, 0);
        check("rst_out_tdata", axis_out_tdata, 0);
        check("rst_out_tlast", axis_out_tlast, 0);
        check("rst_bus_sel", bus_sel, 0);
        check("rst_in_tready", axis_in_tready, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Single 4-beat packet on channel 3
        @(negedge clk);
        send_pkt(3, 4, 32'hA0);
        @(negedge clk);
        check("t1_sel_before_grant", bus_sel, 0);
        @(negedge clk);
        check("t1_sel_grant", bus_sel, 131);
        check("t1_in_tready", axis_in_tready, 14'h0008);
        @(negedge clk);
        check("t1_first_out_valid", axis_out_tvalid, 1);
        check("t1_first_out_data", axis_out_tdata, 32'hA0);
        check("t1_first_out_last", axis_out_tlast, 0);
        @(negedge clk);
        @(negedge clk);
        check("t1_sel_held", bus_sel, 131);
        @(negedge clk);
        check("t1_sel_released", bus_sel, 0);
        check("t1_last_data", axis_out_tdata, 32'hA3);
        check("t1_last_flag", axis_out_tlast, 1);
        @(negedge clk);
        check("t1_out_empty", axis_out_tvalid, 0);
        drain("t1_drain");

        // Three contending channels from reset priority, then channel 0 re-requests
        pulse_reset();
        send_pkt(0, 2, 32'hB000);
        send_pkt(5, 2, 32'hB500);
        send_pkt(13, 2, 32'hBD00);
        wait_sel(128, "t2_grant_ch0");
        wait_sel(133, "t2_grant_ch5");
        wait_sel(141, "t2_grant_ch13");
        send_pkt(0, 2, 32'hB010);
        wait_sel(0, "t2_idle_gap");
        wait_sel(128, "t2_regrant_ch0");
        drain("t2_drain");

        // Channel 1 requests while channel 2 is mid-packet
        send_pkt(2, 3, 32'hC200);
        wait_sel(130, "t3_grant_ch2");
        send_pkt(1, 2, 32'hC100);
        wait_sel(0, "t3_ch2_done");
        wait_sel(129, "t3_grant_ch1");
        drain("t3_drain");

        // Downstream stall for 5 cycles after the first beat loads
        send_pkt(4, 4, 32'hC0);
        wait_sel(132, "t4_grant_ch4");
        @(posedge clk);
        #1 axis_out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t4_stall%0d_valid", i), axis_out_tvalid, 1);
            check($sformatf("t4_stall%0d_data", i), axis_out_tdata, 32'hC0);
            check($sformatf("t4_stall%0d_last", i), axis_out_tlast, 0);
            check($sformatf("t4_stall%0d_in_tready", i), axis_in_tready, 0);
        end
        @(posedge clk);
        #1 axis_out_tready = 1'b1;
        drain("t4_drain");

        // Asynchronous reset in the middle of a channel 7 packet
        send_pkt(7, 4, 32'hD0);
        wait_sel(135, "t5_grant_ch7");
        @(negedge clk);
        #2 rst = 1'b1;
        flush_all();
        #1;
        check("t5_rst_out_tvalid", axis_out_tvalid, 0);
        check("t5_rst_out_tdata", axis_out_tdata, 0);
        check("t5_rst_out_tlast", axis_out_tlast, 0);
        check("t5_rst_bus_sel", bus_sel, 0);
        check("t5_rst_in_tready", axis_in_tready, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        send_pkt(0, 2, 32'hE000);
        send_pkt(7, 2, 32'hE700);
        wait_sel(128, "t5_ch0_first");
        wait_sel(135, "t5_ch7_second");
        drain("t5_drain");

        // Random traffic on all channels with random downstream backpressure
        rand_mode = 1'b1;
        open_ch   = -1;
        for (int c = 0; c < NC; c++) begin
            for (int p = 0; p < 30; p++) begin
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    b.data = {8'(c), 8'(p), 8'(k), 8'($urandom_range(255))};
                    b.last = (k == len - 1);
                    src_q[c].push_back(b);
                    exp_ch_q[c].push_back(b);
                end
            end
        end
        repeat (10000) @(posedge clk);
        @(negedge clk);
        #2;
        rand_mode = 1'b0;
        axis_out_tready = 1'b1;
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
